// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode constants, opcode type and scheduler FSM states.
// Used by the alu_sched scheduler, its arbiter and the ALU benches.
package alu_pkg;

  typedef logic [1:0] opc_t;

  localparam opc_t OPC_ADD = 2'd0;
  localparam opc_t OPC_SUB = 2'd1;
  localparam opc_t OPC_AND = 2'd2;
  localparam opc_t OPC_OR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } state_t;

  // Only the arithmetic opcodes carry a meaningful overflow flag.
  function automatic logic opc_has_ovf(input opc_t opc);
    return (opc == OPC_ADD) || (opc == OPC_SUB);
  endfunction

endpackage

// File: rtl/alu_sched_rr_arbiter.sv
// rr_arbiter: combinational requester selection for alu_sched.
// Build option ALU_SCHED_RR_EN: when defined, round-robin search starting
// after the last winner; when undefined, fixed priority (lowest index wins)
// and i_last is ignored.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  input  logic          i_en,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx
);

  logic w_found;

`ifdef ALU_SCHED_RR_EN
  logic [IW-1:0] w_pos;

  // Walk last+1, last+2, ... modulo N and take the first active request.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_pos   = '0;
    for (int k = 1; k <= N; k++) begin
      w_pos = IW'((int'(i_last) + k) % N);
      if (!w_found && i_req[w_pos]) begin
        o_gnt[w_pos] = 1'b1;
        o_idx        = w_pos;
        w_found      = 1'b1;
      end
    end
    if (!i_en) begin
      o_gnt = '0;
    end
  end
`else
  logic unused_last;
  assign unused_last = ^i_last;

  // Lowest asserted request index wins.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!w_found && i_req[IW'(k)]) begin
        o_gnt[IW'(k)] = 1'b1;
        o_idx         = IW'(k);
        w_found       = 1'b1;
      end
    end
    if (!i_en) begin
      o_gnt = '0;
    end
  end
`endif

endmodule

// File: rtl/alu_sched.sv
// alu_sched: shares one registered 2-bit-opcode 32-bit ALU between REQ_CNT
// requesters. One op in flight: IDLE (grant) -> EXEC (ALU samples operands)
// -> CAPT (capture result) -> RESP (valid/ready result port).
// Build option ALU_SCHED_RR_EN selects round-robin arbitration; otherwise
// fixed priority.
module alu_sched
  import alu_pkg::*;
#(
  parameter int REQ_CNT = 4,
  parameter int ID_W    = $clog2(REQ_CNT)
) (
  input  logic                    Clk_i,
  input  logic                    Reset_i,
  input  logic [REQ_CNT-1:0]      Req_i,
  input  logic [2*REQ_CNT-1:0]    Opc_i,
  input  logic [32*REQ_CNT-1:0]   DinA_i,
  input  logic [32*REQ_CNT-1:0]   DinB_i,
  output logic [REQ_CNT-1:0]      Gnt_o,
  output logic                    Busy_o,
  output logic [1:0]              Alu_Opc_o,
  output logic [31:0]             Alu_DinA_o,
  output logic [31:0]             Alu_DinB_o,
  input  logic [31:0]             Alu_Dout_i,
  input  logic                    Alu_OverFlow_i,
  output logic                    Res_Valid_o,
  input  logic                    Res_Ready_i,
  output logic [ID_W-1:0]         Res_Id_o,
  output logic [31:0]             Res_Dout_o,
  output logic                    Res_OverFlow_o
);

  state_t          r_state;
  opc_t            r_alu_opc;
  logic [31:0]     r_alu_a;
  logic [31:0]     r_alu_b;
  logic [ID_W-1:0] r_id;
  logic [ID_W-1:0] r_last;
  logic            r_res_valid;
  logic [31:0]     r_res_dout;
  logic            r_res_ovf;

  logic               w_idle;
  logic [REQ_CNT-1:0] w_gnt;
  logic [ID_W-1:0]    w_idx;
  opc_t               w_opc_arr [REQ_CNT];
  logic [31:0]        w_a_arr   [REQ_CNT];
  logic [31:0]        w_b_arr   [REQ_CNT];

  // Unpack the flat per-requester buses so the winner can be indexed.
  for (genvar gi = 0; gi < REQ_CNT; gi++) begin : g_slice
    assign w_opc_arr[gi] = Opc_i[2*gi +: 2];
    assign w_a_arr[gi]   = DinA_i[32*gi +: 32];
    assign w_b_arr[gi]   = DinB_i[32*gi +: 32];
  end

  assign w_idle = (r_state == IDLE);

  rr_arbiter #(
    .N  (REQ_CNT),
    .IW (ID_W)
  ) u_arb (
    .i_req  (Req_i),
    .i_last (r_last),
    .i_en   (w_idle),
    .o_gnt  (w_gnt),
    .o_idx  (w_idx)
  );

  // Grant is combinational in IDLE; reset forces it low immediately.
  assign Gnt_o          = Reset_i ? '0 : w_gnt;
  assign Busy_o         = ~w_idle;
  assign Alu_Opc_o      = r_alu_opc;
  assign Alu_DinA_o     = r_alu_a;
  assign Alu_DinB_o     = r_alu_b;
  assign Res_Valid_o    = r_res_valid;
  assign Res_Id_o       = r_id;
  assign Res_Dout_o     = r_res_dout;
  assign Res_OverFlow_o = r_res_ovf;

  // Scheduler FSM: load winner operands, wait for the ALU, capture, hand off.
  always_ff @(posedge Clk_i or posedge Reset_i) begin
    if (Reset_i) begin
      r_state     <= IDLE;
      r_alu_opc   <= OPC_ADD;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_id        <= '0;
      r_last      <= ID_W'(REQ_CNT - 1);
      r_res_valid <= 1'b0;
      r_res_dout  <= '0;
      r_res_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|Req_i) begin
            r_alu_opc <= w_opc_arr[w_idx];
            r_alu_a   <= w_a_arr[w_idx];
            r_alu_b   <= w_b_arr[w_idx];
            r_id      <= w_idx;
            r_last    <= w_idx;
            r_state   <= EXEC;
          end
        end
        EXEC: begin
          r_state <= CAPT;
        end
        CAPT: begin
          r_res_dout  <= Alu_Dout_i;
          // Logic ops have no overflow; drop whatever the ALU reports.
          r_res_ovf   <= opc_has_ovf(r_alu_opc) & Alu_OverFlow_i;
          r_res_valid <= 1'b1;
          r_state     <= RESP;
        end
        RESP: begin
          if (Res_Ready_i) begin
            r_res_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: scoreboard bench for alu_sched with a registered ALU model.
// Honours ALU_SCHED_RR_EN in its reference arbitration model.
module tb_alu_sched;
  import alu_pkg::*;

  localparam int N = 4;

  typedef struct {
    int          id;
    logic [31:0] dout;
    logic        ovf;
    int          gcyc;
  } exp_t;

  logic         Clk_i = 1'b0;
  logic         Reset_i;
  logic [3:0]   Req_i;
  logic [7:0]   Opc_i;
  logic [127:0] DinA_i;
  logic [127:0] DinB_i;
  logic [3:0]   Gnt_o;
  logic         Busy_o;
  logic [1:0]   Alu_Opc_o;
  logic [31:0]  Alu_DinA_o;
  logic [31:0]  Alu_DinB_o;
  logic [31:0]  Alu_Dout_i = '0;
  logic         Alu_OverFlow_i = 1'b0;
  logic         Res_Valid_o;
  logic         Res_Ready_i;
  logic [1:0]   Res_Id_o;
  logic [31:0]  Res_Dout_o;
  logic         Res_OverFlow_o;

  always #5 Clk_i = ~Clk_i;

  alu_sched #(.REQ_CNT(N)) dut (
    .Clk_i          (Clk_i),
    .Reset_i        (Reset_i),
    .Req_i          (Req_i),
    .Opc_i          (Opc_i),
    .DinA_i         (DinA_i),
    .DinB_i         (DinB_i),
    .Gnt_o          (Gnt_o),
    .Busy_o         (Busy_o),
    .Alu_Opc_o      (Alu_Opc_o),
    .Alu_DinA_o     (Alu_DinA_o),
    .Alu_DinB_o     (Alu_DinB_o),
    .Alu_Dout_i     (Alu_Dout_i),
    .Alu_OverFlow_i (Alu_OverFlow_i),
    .Res_Valid_o    (Res_Valid_o),
    .Res_Ready_i    (Res_Ready_i),
    .Res_Id_o       (Res_Id_o),
    .Res_Dout_o     (Res_Dout_o),
    .Res_OverFlow_o (Res_OverFlow_o)
  );

  // Registered ALU: carry/borrow as overflow, logic ops always flag overflow
  // so that the scheduler's masking is exercised on every AND/OR.
  always @(posedge Clk_i) begin
    case (Alu_Opc_o)
      2'd0:    {Alu_OverFlow_i, Alu_Dout_i} <= {1'b0, Alu_DinA_o} + {1'b0, Alu_DinB_o};
      2'd1:    {Alu_OverFlow_i, Alu_Dout_i} <= {1'b0, Alu_DinA_o} - {1'b0, Alu_DinB_o};
      2'd2:    begin Alu_Dout_i <= Alu_DinA_o & Alu_DinB_o; Alu_OverFlow_i <= 1'b1; end
      default: begin Alu_Dout_i <= Alu_DinA_o | Alu_DinB_o; Alu_OverFlow_i <= 1'b1; end
    endcase
  end

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   free_cyc = 0;
  int   model_last = N - 1;
  bit   first_seen = 0;
  exp_t sb[$];

  logic [1:0]  opc_m [N];
  logic [31:0] a_m   [N];
  logic [31:0] b_m   [N];
  logic [3:0]  req_m;

  always @(posedge Clk_i) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference result: plain arithmetic from the opcode definitions.
  function automatic exp_t model(input int id, input logic [1:0] op,
                                 input logic [31:0] a, input logic [31:0] b, input int gc);
    exp_t e;
    e.id = id;
    e.gcyc = gc;
    case (op)
      OPC_ADD: begin e.dout = a + b; e.ovf = (a > 32'hFFFF_FFFF - b); end
      OPC_SUB: begin e.dout = a - b; e.ovf = (a < b); end
      OPC_AND: begin e.dout = a & b; e.ovf = 1'b0; end
      default: begin e.dout = a | b; e.ovf = 1'b0; end
    endcase
    return e;
  endfunction

  // Reference arbitration: which requester should win given the request set.
  function automatic int pick(input logic [3:0] r, input int last);
`ifdef ALU_SCHED_RR_EN
    for (int s = 1; s <= N; s++) begin
      if (r[(last + s) % N]) return (last + s) % N;
    end
`else
    for (int s = 0; s < N; s++) begin
      if (r[s]) return s;
    end
`endif
    return -1;
  endfunction

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      Opc_i[2*k +: 2]   = opc_m[k];
      DinA_i[32*k +: 32] = a_m[k];
      DinB_i[32*k +: 32] = b_m[k];
    end
    Req_i = req_m;
  endtask

  task automatic set_req(input int k, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    opc_m[k] = op;
    a_m[k]   = a;
    b_m[k]   = b;
    req_m[k] = 1'b1;
    drive();
  endtask

  task automatic set_rand(input int k);
    logic [31:0] a;
    logic [31:0] b;
    a = $urandom;
    b = ($urandom_range(0, 3) == 0) ? a : 32'($urandom);
    set_req(k, 2'($urandom_range(0, 3)), a, b);
  endtask

  // One clock: check grant/busy against the model, then retire the granted request.
  task automatic tick(output int g);
    logic [3:0] exp_gnt;
    @(negedge Clk_i);
    #1;
    g = (cyc >= free_cyc) ? pick(req_m, model_last) : -1;
    exp_gnt = (g >= 0) ? 4'(1 << g) : 4'b0;
    chk("gnt", 32'(Gnt_o), 32'(exp_gnt));
    chk("busy", 32'(Busy_o), 32'(cyc < free_cyc));
    if (g >= 0) begin
      sb.push_back(model(g, opc_m[g], a_m[g], b_m[g], cyc));
      free_cyc = 1 << 30;
      model_last = g;
    end
    @(posedge Clk_i);
    #1;
    if (g >= 0) begin
      req_m[g] = 1'b0;
      drive();
    end
  endtask

  task automatic run_until_idle(input int max);
    int n;
    int g;
    n = 0;
    while ((req_m != 0 || sb.size() != 0 || cyc < free_cyc) && n < max) begin
      tick(g);
      n++;
    end
    if (req_m != 0 || sb.size() != 0 || cyc < free_cyc) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: %0d ops outstanding after %0d cycles, required 0", sb.size(), max);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_gnt"}, 32'(Gnt_o), 0);
    chk({tag, "_busy"}, 32'(Busy_o), 0);
    chk({tag, "_alu_opc"}, 32'(Alu_Opc_o), 0);
    chk({tag, "_alu_a"}, Alu_DinA_o, 0);
    chk({tag, "_alu_b"}, Alu_DinB_o, 0);
    chk({tag, "_valid"}, 32'(Res_Valid_o), 0);
    chk({tag, "_id"}, 32'(Res_Id_o), 0);
    chk({tag, "_dout"}, Res_Dout_o, 0);
    chk({tag, "_ovf"}, 32'(Res_OverFlow_o), 0);
  endtask

  // Result monitor: compares every presented result against the scoreboard head.
  always @(negedge Clk_i) begin
    if (!Reset_i && Res_Valid_o) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_result: got valid id=%0d, required no result outstanding", Res_Id_o);
      end else begin
        chk("res_id", 32'(Res_Id_o), 32'(sb[0].id));
        chk("res_dout", Res_Dout_o, sb[0].dout);
        chk("res_ovf", 32'(Res_OverFlow_o), 32'(sb[0].ovf));
        if (!first_seen) chk("latency", 32'(cyc - sb[0].gcyc), 32'd3);
        first_seen = 1;
        if (Res_Ready_i) begin
          $display("txn id=%0d dout=%h ovf=%0d cycle=%0d", Res_Id_o, Res_Dout_o, Res_OverFlow_o, cyc);
          void'(sb.pop_front());
          first_seen = 0;
          free_cyc = cyc + 1;
        end
      end
    end
  end

  // Protocol watch: a request may only fall after it has been granted.
  logic [3:0] prev_req = '0;
  logic [3:0] prev_gnt = '0;
  always @(posedge Clk_i) begin
    if (!Reset_i) begin
      for (int k = 0; k < N; k++) begin
        if (prev_req[k] && !Req_i[k] && !prev_gnt[k]) begin
          vectors++;
          miscompares++;
          $display("FAIL req_drop: requester %0d dropped, required held until grant", k);
        end
      end
    end
    prev_req <= Req_i;
    prev_gnt <= Gnt_o;
  end

  initial begin
    int g;
    int grants;
    int n;
    Reset_i = 1'b0;
    Res_Ready_i = 1'b1;
    req_m = '0;
    for (int k = 0; k < N; k++) begin
      opc_m[k] = '0;
      a_m[k] = '0;
      b_m[k] = '0;
    end
    drive();
    #3 Reset_i = 1'b1;
    @(negedge Clk_i);
    @(negedge Clk_i);
    check_zero("reset");
    @(posedge Clk_i);
    #1 Reset_i = 1'b0;

    // Single ADD with carry out.
    set_req(0, OPC_ADD, 32'hFFFF_FFFF, 32'h1);
    run_until_idle(20);

    // All requesters active, re-raised after each grant.
    for (int k = 0; k < N; k++) set_rand(k);
    grants = 0;
    n = 0;
    while (grants < 5 && n < 60) begin
      tick(g);
      n++;
      if (g >= 0) begin
        grants++;
        set_rand(g);
      end
    end
    chk("rr_grant_count", 32'(grants), 32'd5);
    run_until_idle(100);

    // Requesters 1 and 3 together.
    set_rand(1);
    set_rand(3);
    run_until_idle(40);

    // AND with overflow from the ALU that must be masked.
    set_req(2, OPC_AND, 32'hF0F0_F0F0, 32'hFF00_FF00);
    run_until_idle(20);

    // Back-pressure with a pending request behind it.
    Res_Ready_i = 1'b0;
    set_rand(2);
    tick(g);
    set_rand(2);
    repeat (8) tick(g);
    Res_Ready_i = 1'b1;
    run_until_idle(40);

    // Reset while the op is in CAPT.
    set_req(0, OPC_SUB, 32'($urandom), 32'($urandom));
    tick(g);
    @(posedge Clk_i);
    #3 Reset_i = 1'b1;
    #1 check_zero("midrst");
    sb.delete();
    free_cyc = 0;
    model_last = N - 1;
    first_seen = 0;
    @(negedge Clk_i);
    @(posedge Clk_i);
    #1 Reset_i = 1'b0;
    set_rand(0);
    set_rand(2);
    run_until_idle(40);

    // Random traffic with random back-pressure.
    for (int i = 0; i < 400; i++) begin
      Res_Ready_i = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < N; k++) begin
        if (!req_m[k] && $urandom_range(0, 2) == 0) set_rand(k);
      end
      tick(g);
    end
    Res_Ready_i = 1'b1;
    run_until_idle(300);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
